// File: rtl/seq_divider.sv
// seq_divider: restoring sequential divider, one quotient bit per clock, valid/ready on both sides.
// Optional macro SEQ_DIVIDER_SIGNED_EN: two's complement operands, magnitude divide plus a FIX state.
module seq_divider #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [DATAW-1:0] i_dividend,
  input  logic [DATAW-1:0] i_divisor,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [DATAW-1:0] o_quotient,
  output logic [DATAW-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CNTW = (DATAW > 2) ? $clog2(DATAW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [DATAW-1:0]  num_q, num_d;
  logic [DATAW-1:0]  den_q, den_d;
  logic [DATAW-1:0]  rem_q, rem_d;
  logic [DATAW-1:0]  quo_q, quo_d;
  logic [DATAW-1:0]  quotient_q, quotient_d;
  logic [DATAW-1:0]  remainder_q, remainder_d;
  logic              dz_q, dz_d;

  logic [DATAW-1:0]  n_mag, d_mag;
  logic              div_zero;
  logic [DATAW:0]    rem_shift, trial;
  logic [DATAW-1:0]  rem_next, quo_next;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic              n_neg, d_neg;

  assign n_neg = i_dividend[DATAW-1];
  assign d_neg = i_divisor[DATAW-1];
  // -2^(DATAW-1) maps onto itself, which reads correctly as an unsigned magnitude.
  assign n_mag = n_neg ? -i_dividend : i_dividend;
  assign d_mag = d_neg ? -i_divisor  : i_divisor;
`else
  assign n_mag = i_dividend;
  assign d_mag = i_divisor;
`endif

  assign div_zero  = (i_divisor == '0);

  // Trial subtraction on DATAW+1 bits: the top bit is the borrow.
  assign rem_shift = {rem_q, num_q[DATAW-1]};
  assign trial     = rem_shift - {1'b0, den_q};
  assign rem_next  = trial[DATAW] ? rem_shift[DATAW-1:0] : trial[DATAW-1:0];
  assign quo_next  = {quo_q[DATAW-2:0], ~trial[DATAW]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d = div_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          state_d = FIX;
`else
          state_d = DONE;
`endif
        end
      end
      FIX: begin
        state_d = DONE;
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      IDLE:    o_ready = 1'b1;
      DONE:    o_valid = 1'b1;
      default: begin
        o_ready = 1'b0;
        o_valid = 1'b0;
      end
    endcase
  end

  // Datapath next values
  always_comb begin
    cnt_d       = cnt_q;
    num_d       = num_q;
    den_d       = den_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          num_d = n_mag;
          den_d = d_mag;
          cnt_d = CNTW'(DATAW - 1);
          rem_d = '0;
          quo_d = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
          q_neg_d = n_neg ^ d_neg;
          r_neg_d = n_neg;
`endif
          // Divide-by-zero skips the iteration and publishes its result at once.
          if (div_zero) begin
            quotient_d  = '1;
            remainder_d = i_dividend;
            dz_d        = 1'b1;
          end
        end
      end
      CALC: begin
        num_d = {num_q[DATAW-2:0], 1'b0};
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q - CNTW'(1);
`ifndef SEQ_DIVIDER_SIGNED_EN
        if (cnt_q == '0) begin
          quotient_d  = quo_next;
          remainder_d = rem_next;
          dz_d        = 1'b0;
        end
`endif
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      FIX: begin
        // Truncation toward zero: remainder follows the dividend's sign.
        quotient_d  = q_neg_q ? -quo_q : quo_q;
        remainder_d = r_neg_q ? -rem_q : rem_q;
        dz_d        = 1'b0;
      end
`endif
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      num_q       <= '0;
      den_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      den_q       <= den_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
`endif
    end
  end

  assign o_quotient    = quotient_q;
  assign o_remainder   = remainder_q;
  assign o_div_by_zero = dz_q;

endmodule
